lora_bcd_convert: RTL and testbench

//  Parametrised binary-to-packed-BCD converter for LoRa RX payload values feeding the display path.

---
 rtl/lora_bcd_convert_if.sv | 22 ++
 rtl/lora_bcd_convert.sv | 148 ++++++++++++++
 tb/tb_lora_bcd_convert.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lora_bcd_convert_if.sv
// ============================================================================
// lora_bcd_convert_if : request/result bundle for the binary-to-BCD converter
// Rev 1.0
// ============================================================================
`default_nettype none

interface lora_bcd_convert_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic [BIN_W-1:0]    bin_in;
  logic                start;
  logic                busy;
  logic [4*DIGITS-1:0] bcd_out;
  logic                valid;
  logic                ovf;

  modport master (output bin_in, start, input busy, bcd_out, valid, ovf);
  modport slave  (input bin_in, start, output busy, bcd_out, valid, ovf);
endinterface

`default_nettype wire

// File: rtl/lora_bcd_convert.sv
// ============================================================================
// lora_bcd_convert : iterative shift-add-3 binary to packed BCD converter.
// Optional periodic self-capture when AUTO_SAMPLE_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module lora_bcd_convert #(
  parameter int BIN_W         = 16,
  parameter int DIGITS        = 5,
  parameter int SAMPLE_CYCLES = 50_000_000
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  lora_bcd_convert_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_work_q, bcd_work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_work_q, ovf_work_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic               tick;
  logic               req;

`ifdef AUTO_SAMPLE_EN
  localparam int SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CYCLES - 1);

  logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;

  assign tick = (smp_cnt_q == SMP_LAST);

  always_comb begin
    smp_cnt_d = tick ? '0 : smp_cnt_q + SMP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) smp_cnt_q <= '0;
    else        smp_cnt_q <= smp_cnt_d;
  end
`else
  // Period is meaningless without the sampler; keep the parameter referenced.
  logic unused_sample_cycles;
  assign unused_sample_cycles = (SAMPLE_CYCLES > 0);
  assign tick = 1'b0;
`endif

  assign req = bus.start | tick;

  // Add-3 correction on every digit before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = bcd_work_q[4*i +: 4] +
                          ((bcd_work_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_sr_d   = bin_sr_q;
    bcd_work_d = bcd_work_q;
    cnt_d      = cnt_q;
    ovf_work_d = ovf_work_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    bcd_out_d  = bcd_out_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d    = S_SHIFT;
          bin_sr_d   = bus.bin_in;
          bcd_work_d = '0;
          cnt_d      = '0;
          ovf_work_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_SHIFT: begin
        bcd_work_d = {bcd_adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
        bin_sr_d   = bin_sr_q << 1;
        ovf_work_d = ovf_work_q | bcd_adj[BCD_W-1];
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_out_d = bcd_work_q;
        ovf_d     = ovf_work_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_sr_q   <= '0;
      bcd_work_q <= '0;
      cnt_q      <= '0;
      ovf_work_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      bin_sr_q   <= bin_sr_d;
      bcd_work_q <= bcd_work_d;
      cnt_q      <= cnt_d;
      ovf_work_q <= ovf_work_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      bcd_out_q  <= bcd_out_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_out_q;

endmodule

`default_nettype wire

// File: tb/tb_lora_bcd_convert.sv
// ============================================================================
// tb_lora_bcd_convert : checks 5-digit and 3-digit converters side by side.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lora_bcd_convert;

  localparam int BIN_W = 16;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             start  = 1'b0;
  int               checks = 0;
  int               errors = 0;
  int               cyc    = 0;

  logic [19:0] prev5  = '0;
  logic        prevo5 = 1'b0;
  logic [11:0] prev3  = '0;
  logic        prevo3 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lora_bcd_convert_if #(.BIN_W(BIN_W), .DIGITS(5)) if5 ();
  lora_bcd_convert_if #(.BIN_W(BIN_W), .DIGITS(3)) if3 ();

  assign if5.bin_in = bin_in;
  assign if5.start  = start;
  assign if3.bin_in = bin_in;
  assign if3.start  = start;

  lora_bcd_convert #(.BIN_W(BIN_W), .DIGITS(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  lora_bcd_convert #(.BIN_W(BIN_W), .DIGITS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

`ifdef AUTO_SAMPLE_EN
  logic start6 = 1'b0;
  lora_bcd_convert_if #(.BIN_W(BIN_W), .DIGITS(5)) if6 ();
  assign if6.bin_in = 16'd255;
  assign if6.start  = start6;
  lora_bcd_convert #(.BIN_W(BIN_W), .DIGITS(5), .SAMPLE_CYCLES(40)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .bus(if6));
`endif

  // Reference: decimal digits of v modulo 10^d, packed 4 bits per digit.
  function automatic logic [19:0] ref_bcd(input longint unsigned v, input int d);
    logic [19:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int d);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    return v >= lim;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid5(output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (if5.valid) begin
        c  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_conv(input logic [15:0] v, input logic [19:0] e5, input logic o5,
                          input logic [11:0] e3, input logic o3, input string tag);
    int   lat;
    int   busy_n;
    logic stable;
    logic seen;
    lat    = 0;
    busy_n = 0;
    stable = 1'b1;
    seen   = 1'b0;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (if5.busy) busy_n++;
    while (lat < 40 && !seen) begin
      bin_in = 16'($urandom);
      if (if5.bcd_out !== prev5 || if3.bcd_out !== prev3 || if5.ovf !== prevo5 ||
          if3.ovf !== prevo3 || if5.valid || if3.valid) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (if5.valid) seen = 1'b1;
      else if (if5.busy) busy_n++;
    end
    check({tag, " latency"}, lat, BIN_W + 1);
    check({tag, " busy_cycles"}, busy_n, BIN_W + 1);
    check({tag, " outputs_stable"}, stable, 1'b1);
    check({tag, " bcd5"}, if5.bcd_out, e5);
    check({tag, " ovf5"}, if5.ovf, o5);
    check({tag, " bcd3"}, if3.bcd_out, e3);
    check({tag, " ovf3"}, if3.ovf, o3);
    check({tag, " valid3"}, if3.valid, 1'b1);
    check({tag, " busy_at_valid"}, if5.busy, 1'b0);
    @(posedge clk); #1;
    check({tag, " valid_pulse"}, {if5.valid, if3.valid}, 2'b00);
    prev5  = e5;
    prevo5 = o5;
    prev3  = e3;
    prevo3 = o3;
  endtask

  typedef struct {
    logic [15:0] v;
    logic [19:0] e5;
    logic        o5;
    logic [11:0] e3;
    logic        o3;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c1, c2, c3, nvalid;
    bit   ok1, ok2, ok3;
    logic [19:0] cap5;
    logic [15:0] rv;

    vecs[0] = '{16'd0,     20'h00000, 1'b0, 12'h000, 1'b0};
    vecs[1] = '{16'd65535, 20'h65535, 1'b0, 12'h535, 1'b1};
    vecs[2] = '{16'd1234,  20'h01234, 1'b0, 12'h234, 1'b1};
    vecs[3] = '{16'd999,   20'h00999, 1'b0, 12'h999, 1'b0};
    vecs[4] = '{16'd1000,  20'h01000, 1'b0, 12'h000, 1'b1};
    vecs[5] = '{16'd9,     20'h00009, 1'b0, 12'h009, 1'b0};
    vecs[6] = '{16'd10,    20'h00010, 1'b0, 12'h010, 1'b0};
    vecs[7] = '{16'd50000, 20'h50000, 1'b0, 12'h000, 1'b1};
    vecs[8] = '{16'd4095,  20'h04095, 1'b0, 12'h095, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {if5.busy, if3.busy}, 2'b00);
    check("reset valid", {if5.valid, if3.valid}, 2'b00);
    check("reset ovf", {if5.ovf, if3.ovf}, 2'b00);
    check("reset bcd5", if5.bcd_out, 20'h0);
    check("reset bcd3", if3.bcd_out, 12'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) run_conv(vecs[i].v, vecs[i].e5, vecs[i].o5, vecs[i].e3, vecs[i].o3, "table");

    for (int i = 0; i < 30; i++) begin
      rv = 16'($urandom_range(0, 65535));
      run_conv(rv, ref_bcd(rv, 5), ref_ovf(rv, 5), 12'(ref_bcd(rv, 3)), ref_ovf(rv, 3), "rand");
    end

    // Second request during a conversion must be dropped.
    @(negedge clk);
    bin_in = 16'd4321;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bin_in = 16'd777;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    nvalid = 0;
    cap5   = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if5.valid) begin
        nvalid++;
        cap5 = if5.bcd_out;
      end
    end
    check("drop count", nvalid, 1);
    check("drop value", cap5, 20'h04321);

    // Held start: back-to-back conversions.
    @(negedge clk);
    bin_in = 16'd2024;
    start  = 1'b1;
    wait_valid5(c1, ok1);
    wait_valid5(c2, ok2);
    wait_valid5(c3, ok3);
    check("held found", {ok1, ok2, ok3}, 3'b111);
    check("held spacing1", c2 - c1, BIN_W + 2);
    check("held spacing2", c3 - c2, BIN_W + 2);
    check("held value", if5.bcd_out, 20'h02024);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && if5.busy; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    prev5 = 20'h02024; prevo5 = 1'b0; prev3 = 12'h024; prevo3 = 1'b1;

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bin_in = 16'd8888;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst busy", {if5.busy, if3.busy}, 2'b00);
    check("midrst valid", {if5.valid, if3.valid}, 2'b00);
    check("midrst ovf", {if5.ovf, if3.ovf}, 2'b00);
    check("midrst bcd5", if5.bcd_out, 20'h0);
    check("midrst bcd3", if3.bcd_out, 12'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (if5.valid || if3.valid) nvalid++;
    end
    check("midrst no_valid", nvalid, 0);
    prev5 = '0; prevo5 = 1'b0; prev3 = '0; prevo3 = 1'b0;
    run_conv(16'd8888, 20'h08888, 1'b0, 12'h888, 1'b1, "after_rst");

`ifdef AUTO_SAMPLE_EN
    begin
      int v0, v1, v2, v3;
      bit k0, k1, k2, k3;
      k0 = 1'b0; k1 = 1'b0; k2 = 1'b0; k3 = 1'b0;
      v0 = 0; v1 = 0; v2 = 0; v3 = 0;
      for (int i = 0; i < 100 && !k0; i++) begin
        @(posedge clk); #1;
        if (if6.valid) begin v0 = cyc; k0 = 1'b1; end
      end
      check("auto value", if6.bcd_out, 20'h00255);
      for (int i = 0; i < 100 && !k1; i++) begin
        @(posedge clk); #1;
        if (if6.valid) begin v1 = cyc; k1 = 1'b1; end
      end
      check("auto period", v1 - v0, 40);
      repeat (19) @(posedge clk);
      @(negedge clk);
      start6 = 1'b1;
      @(posedge clk); #1;
      start6 = 1'b0;
      for (int i = 0; i < 100 && !k2; i++) begin
        @(posedge clk); #1;
        if (if6.valid) begin v2 = cyc; k2 = 1'b1; end
      end
      for (int i = 0; i < 100 && !k3; i++) begin
        @(posedge clk); #1;
        if (if6.valid) begin v3 = cyc; k3 = 1'b1; end
      end
      check("auto found", {k0, k1, k2, k3}, 4'b1111);
      check("auto start_valid", v2 - v1, 37);
      check("auto tick_dropped", v3 - v1, 80);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
